divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 28 ++
 rtl/divider.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/divider_pkg.sv
// Shared divider definitions: ALU op codes, FSM state encodings, widths and
// the result payload layout used by the divider and its consumers.
package divider_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORK_W = 2 * DATA_W + 1;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ALU_W  = 8;

  // Execute-stage ALU control codes that launch a divide
  localparam logic [ALU_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // Divider FSM state encodings
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Result payload: remainder goes to HI, quotient to LO
  typedef struct packed {
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/divider.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for the execute stage.
// One shift-subtract step per cycle over 32 cycles; divide-by-zero takes a
// short path that returns zero. Define DIV_ANNUL_EN to let a pipeline flush
// (annul) cancel an operation in flight; by default annul is ignored.
module divider
  import divider_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [ALU_W-1:0]    alucontrol,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                annul,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                busy
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  div_result_t         result_q, result_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                annul_hit;
  logic                op_valid;
  logic                is_signed;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [WORK_W-1:0]   work_sh;
  logic [DATA_W+1:0]   diff;
  logic [DATA_W-1:0]   quo_raw;
  logic [DATA_W-1:0]   rem_raw;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

`ifdef DIV_ANNUL_EN
  assign annul_hit = annul;
`else
  logic unused_annul;
  assign unused_annul = annul;
  assign annul_hit    = 1'b0;
`endif

  // Operand decode and magnitude extraction for signed divides
  assign op_valid  = start && ((alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP));
  assign is_signed = (alucontrol == EXE_DIV_OP);
  assign abs_a     = (is_signed && a[DATA_W-1]) ? (~a) + DATA_W'(1) : a;
  assign abs_b     = (is_signed && b[DATA_W-1]) ? (~b) + DATA_W'(1) : b;

  // One restoring step: shift left, trial-subtract divisor from upper half
  assign work_sh = work_q << 1;
  assign diff    = {1'b0, work_sh[WORK_W-1:DATA_W]} - {2'b00, divisor_q};

  // Sign fix-up of the final quotient and remainder
  assign quo_raw = work_q[DATA_W-1:0];
  assign rem_raw = work_q[2*DATA_W-1:DATA_W];
  assign quo_fix = neg_quo_q ? (~quo_raw) + DATA_W'(1) : quo_raw;
  assign rem_fix = neg_rem_q ? (~rem_raw) + DATA_W'(1) : rem_raw;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (op_valid && !annul_hit) begin
          work_d    = {(WORK_W-DATA_W)'(0), abs_a};
          divisor_d = abs_b;
          neg_quo_d = is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
          neg_rem_d = is_signed && a[DATA_W-1];
          cnt_d     = '0;
          state_d   = (b == '0) ? DIV_DIVZERO : DIV_ON;
        end
      end
      DIV_DIVZERO: begin
        work_d    = '0;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        state_d   = annul_hit ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        if (!diff[DATA_W+1]) begin
          work_d = {diff[DATA_W:0], work_sh[DATA_W-1:1], 1'b1};
        end else begin
          work_d = work_sh;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (annul_hit) begin
          state_d = DIV_IDLE;
        end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        result_d.rem = rem_fix;
        result_d.quo = quo_fix;
        ready_d      = 1'b1;
        state_d      = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    busy_d = (state_d == DIV_DIVZERO) || (state_d == DIV_ON);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule
